// File: rtl/posit_pio_pkg.sv
// Shared types and constants for the HPS PIO to posit-core sequencer.
package posit_pio_pkg;

  localparam int unsigned POSIT_WIDTH = 32;
  localparam int unsigned MEM_ADDR_W  = 12;
  localparam logic [POSIT_WIDTH-1:0] POSIT_NAR = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    LOG   = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  // Operand pair latched on a start request and presented to the core.
  typedef struct packed {
    logic [POSIT_WIDTH-1:0] num1;
    logic [POSIT_WIDTH-1:0] num2;
  } posit_req_t;

endpackage

// File: rtl/posit_pio_sequencer_if.sv
// Valid/ready request and single-pulse response channel to the posit core.
interface posit_pio_sequencer_if;
  import posit_pio_pkg::*;

  logic                   core_req_valid;
  logic                   core_req_ready;
  logic [POSIT_WIDTH-1:0] core_num1;
  logic [POSIT_WIDTH-1:0] core_num2;
  logic                   core_resp_valid;
  logic [POSIT_WIDTH-1:0] core_resp_result;

  modport master (
    output core_req_valid, core_num1, core_num2,
    input  core_req_ready, core_resp_valid, core_resp_result
  );

  modport slave (
    input  core_req_valid, core_num1, core_num2,
    output core_req_ready, core_resp_valid, core_resp_result
  );

endinterface

// File: rtl/posit_log_writer.sv
// Writes one 32-bit result as four little-endian bytes into a ring log on the
// on-chip memory s2 port; started by a one-cycle pulse, reports done combinationally.
module posit_log_writer
  import posit_pio_pkg::*;
#(
  parameter int unsigned LOG_ENTRIES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [POSIT_WIDTH-1:0] data_i,
  output logic                   done_c_o,
  output logic [MEM_ADDR_W-1:0]  mem_address_o,
  output logic                   mem_chipselect_o,
  output logic                   mem_clken_o,
  output logic                   mem_write_o,
  output logic [7:0]             mem_writedata_o
);

  localparam int unsigned PTR_W = (LOG_ENTRIES > 1) ? $clog2(LOG_ENTRIES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LOG_ENTRIES - 1);

  logic                   active_q, active_d;
  logic [1:0]             idx_q, idx_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [POSIT_WIDTH-1:0] data_q, data_d;
  logic                   wr_en_q, wr_en_d;
  logic [MEM_ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;

  // Byte 0 goes out on the start edge so the four writes follow back to back.
  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    wr_en_d  = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    if (start_i) begin
      active_d = 1'b1;
      idx_d    = 2'd0;
      data_d   = data_i;
      wr_en_d  = 1'b1;
      addr_d   = MEM_ADDR_W'({ptr_q, 2'd0});
      wdata_d  = data_i[7:0];
    end else if (active_q) begin
      if (idx_q == 2'd3) begin
        active_d = 1'b0;
        ptr_d    = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
      end else begin
        idx_d   = idx_q + 2'd1;
        wr_en_d = 1'b1;
        addr_d  = MEM_ADDR_W'({ptr_q, idx_d});
        wdata_d = 8'(data_q >> {idx_d, 3'b000});
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      ptr_q    <= '0;
      data_q   <= '0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign done_c_o         = active_q && (idx_q == 2'd3);
  assign mem_address_o    = addr_q;
  assign mem_chipselect_o = wr_en_q;
  assign mem_clken_o      = wr_en_q;
  assign mem_write_o      = wr_en_q;
  assign mem_writedata_o  = wdata_q;

endmodule

// File: rtl/posit_pio_sequencer.sv
// Sequencer between HPS PIO exports and a posit core: capture operands on a
// start rise, run the core handshake with timeout, publish and log the result.
module posit_pio_sequencer
  import posit_pio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned LOG_ENTRIES    = 1024
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [POSIT_WIDTH-1:0] num1_export,
  input  logic [POSIT_WIDTH-1:0] num2_export,
  input  logic                   start_export,
  output logic [POSIT_WIDTH-1:0] result_export,
  output logic                   completed_export,
  posit_pio_sequencer_if.master  core_if,
  output logic [MEM_ADDR_W-1:0]  mem_address,
  output logic                   mem_chipselect,
  output logic                   mem_clken,
  output logic                   mem_write,
  output logic [7:0]             mem_writedata,
  output logic                   timeout_err
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic                   start_q;
  posit_req_t             op_q, op_d;
  logic                   req_valid_q, req_valid_d;
  logic [POSIT_WIDTH-1:0] result_q, result_d;
  logic                   completed_q, completed_d;
  logic                   terr_q, terr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   request_c;
  logic                   log_start_c;
  logic                   log_done_c;

  // start_q resets high so a level held through reset is not a request.
  assign request_c = start_export && !start_q;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (request_c) state_d = ISSUE;
      ISSUE:   if (core_if.core_req_ready) state_d = WAIT;
      WAIT:    if (core_if.core_resp_valid || (cnt_q == CNT_LAST)) state_d = LOG;
      LOG:     if (log_done_c) state_d = DONE;
      DONE:    if (!start_export) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response wins over timeout when both land in the same WAIT cycle.
  always_comb begin
    op_d        = op_q;
    result_d    = result_q;
    terr_d      = terr_q;
    cnt_d       = cnt_q;
    log_start_c = 1'b0;
    req_valid_d = (state_d == ISSUE);
    completed_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (request_c) begin
          op_d   = '{num1: num1_export, num2: num2_export};
          terr_d = 1'b0;
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_if.core_resp_valid) begin
          result_d    = core_if.core_resp_result;
          log_start_c = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          result_d    = POSIT_NAR;
          terr_d      = 1'b1;
          log_start_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      start_q     <= 1'b1;
      op_q        <= '0;
      req_valid_q <= 1'b0;
      result_q    <= '0;
      completed_q <= 1'b0;
      terr_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      start_q     <= start_export;
      op_q        <= op_d;
      req_valid_q <= req_valid_d;
      result_q    <= result_d;
      completed_q <= completed_d;
      terr_q      <= terr_d;
      cnt_q       <= cnt_d;
    end
  end

  posit_log_writer #(
    .LOG_ENTRIES (LOG_ENTRIES)
  ) u_log_writer (
    .clk_i            (clk_clk),
    .rst_ni           (reset_reset_n),
    .start_i          (log_start_c),
    .data_i           (result_d),
    .done_c_o         (log_done_c),
    .mem_address_o    (mem_address),
    .mem_chipselect_o (mem_chipselect),
    .mem_clken_o      (mem_clken),
    .mem_write_o      (mem_write),
    .mem_writedata_o  (mem_writedata)
  );

  assign result_export          = result_q;
  assign completed_export       = completed_q;
  assign timeout_err            = terr_q;
  assign core_if.core_req_valid = req_valid_q;
  assign core_if.core_num1      = op_q.num1;
  assign core_if.core_num2      = op_q.num2;

endmodule
